// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU execute path: widths, opcodes, FSM states and flag layout.
// Data buses number the sign bit as bit 0; storage is [WIDTH-1:0], so that bit lives at SIGN.
package cpu_pkg;

  localparam int WIDTH = 32;
  localparam int REG_W = 5;
  localparam int OP_W  = 4;
  localparam int SH_W  = 5;
  localparam int SIGN  = WIDTH - 1;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT   = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'd9;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd10;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd11;

  // flags = {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } aluState_t;

  function automatic logic isLegalOp(input logic [OP_W-1:0] op);
    return op <= OP_PASSB;
  endfunction

  function automatic logic [3:0] packFlags(input logic [WIDTH-1:0] res,
                                           input logic carry, input logic ovf);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[SIGN];
    f[FLAG_C] = carry;
    f[FLAG_V] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Controller <-> execute-stage bundle: operand/request side and write-back side.
// Handshake: start is taken only while busy is low; done pulses for exactly one cycle, in
// the same cycle as any WriteC/ill pulse, and nothing is queued while busy is high.
interface alu_exec_if;
  import cpu_pkg::*;

  logic              start;
  logic [OP_W-1:0]   op;
  logic [WIDTH-1:0]  busA;
  logic [WIDTH-1:0]  busB;
  logic [REG_W-1:0]  dest;
  logic [WIDTH-1:0]  busC;
  logic [REG_W-1:0]  busCsel;
  logic              WriteC;
  logic              busy;
  logic              done;
  logic [3:0]        flags;
  logic              ill;

  modport master (
    output start, op, busA, busB, dest,
    input  busC, busCsel, WriteC, busy, done, flags, ill
  );

  modport slave (
    input  start, op, busA, busB, dest,
    output busC, busCsel, WriteC, busy, done, flags, ill
  );

endinterface

// File: rtl/mul_iter.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, product kept mod 2^WIDTH.
// Bit 0 is consumed on the start edge, so done is high in the cycle after the last bit.
module mul_iter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 2);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] iter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      iter    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        product <= multiplier[0] ? multiplicand : '0;
        mcand   <= multiplicand << 1;
        mplier  <= multiplier >> 1;
        iter    <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        iter   <= iter + 1'b1;
        if (iter == LAST_ITER) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: latches operands from the register bank, runs one ALU op or an iterative
// multiply, and presents a one-cycle write-back to the bank on busC/busCsel/WriteC.
module alu_exec
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus,
  output aluState_t dbgState
);

  aluState_t        state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [OP_W-1:0]  opReg;
  logic [REG_W-1:0] destReg;

  logic             mulStart;
  logic             mulBusy;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;

  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] exeResult;
  logic             exeCarry;
  logic             exeOvf;
  logic             exeLegal;
  logic [3:0]       exeFlags;

  assign dbgState = state;

  // The multiplier captures the operands itself on the accept edge.
  assign mulStart = (state == ST_IDLE) && bus.start && (bus.op == OP_MUL);

  mul_iter uMul (
    .clk          (clk),
    .reset        (reset),
    .start        (mulStart),
    .multiplicand (bus.busA),
    .multiplier   (bus.busB),
    .busy         (mulBusy),
    .done         (mulDone),
    .product      (mulProduct)
  );

  always_comb begin
    sumExt    = {1'b0, aReg} + {1'b0, bReg};
    diffExt   = {1'b0, aReg} - {1'b0, bReg};
    shamt     = bReg[SH_W-1:0];
    exeResult = '0;
    exeCarry  = 1'b0;
    exeOvf    = 1'b0;
    exeLegal  = isLegalOp(opReg);
    case (opReg)
      OP_ADD: begin
        exeResult = sumExt[WIDTH-1:0];
        exeCarry  = sumExt[WIDTH];
        exeOvf    = (aReg[SIGN] == bReg[SIGN]) && (sumExt[SIGN] != aReg[SIGN]);
      end
      OP_SUB: begin
        // Top bit of the extended difference is the unsigned borrow (A < B).
        exeResult = diffExt[WIDTH-1:0];
        exeCarry  = diffExt[WIDTH];
        exeOvf    = (aReg[SIGN] != bReg[SIGN]) && (diffExt[SIGN] != aReg[SIGN]);
      end
      OP_AND:   exeResult = aReg & bReg;
      OP_OR:    exeResult = aReg | bReg;
      OP_XOR:   exeResult = aReg ^ bReg;
      OP_SLL:   exeResult = aReg << shamt;
      OP_SRL:   exeResult = aReg >> shamt;
      OP_SRA:   exeResult = $unsigned($signed(aReg) >>> shamt);
      OP_SLT:   exeResult = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
      OP_SLTU:  exeResult = {{(WIDTH-1){1'b0}}, (aReg < bReg)};
      OP_PASSB: exeResult = bReg;
      default:  exeResult = '0;
    endcase
    exeFlags = packFlags(exeResult, exeCarry, exeOvf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      aReg        <= '0;
      bReg        <= '0;
      opReg       <= '0;
      destReg     <= '0;
      bus.busC    <= '0;
      bus.busCsel <= '0;
      bus.WriteC  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.flags   <= '0;
      bus.ill     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            aReg     <= bus.busA;
            bReg     <= bus.busB;
            opReg    <= bus.op;
            destReg  <= bus.dest;
            bus.busy <= 1'b1;
            state    <= (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          state       <= ST_WB;
          bus.done    <= 1'b1;
          bus.ill     <= !exeLegal;
          bus.busC    <= exeResult;
          bus.busCsel <= destReg;
          bus.WriteC  <= exeLegal && (destReg != '0);
          if (exeLegal) bus.flags <= exeFlags;
        end
        ST_MUL: begin
          if (mulDone && !mulBusy) begin
            state       <= ST_WB;
            bus.done    <= 1'b1;
            bus.busC    <= mulProduct;
            bus.busCsel <= destReg;
            bus.WriteC  <= (destReg != '0);
            bus.flags   <= packFlags(mulProduct, 1'b0, 1'b0);
          end
        end
        ST_WB: begin
          state       <= ST_IDLE;
          bus.busC    <= '0;
          bus.busCsel <= '0;
          bus.WriteC  <= 1'b0;
          bus.done    <= 1'b0;
          bus.ill     <= 1'b0;
          bus.busy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vectors push expected write-backs into a queue and a
// negedge monitor pops and compares them whenever the stage reports done.
module tb_alu_exec;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] busC;
    logic [4:0]  sel;
    logic        writeC;
    logic [3:0]  flags;
    logic        ill;
    logic        chkData;
    logic [31:0] doneCyc;
  } exp_t;

  logic      clk = 1'b0;
  logic      reset;
  aluState_t dbgState;
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  logic      prev_done = 1'b0;
  exp_t      exp_q[$];

  alu_exec_if bus ();

  alu_exec dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chkData) begin
            chk("busC", bus.busC, e.busC);
            chk("busCsel", 32'(bus.busCsel), 32'(e.sel));
          end
          chk("WriteC", 32'(bus.WriteC), 32'(e.writeC));
          chk("flags", 32'(bus.flags), 32'(e.flags));
          chk("ill", 32'(bus.ill), 32'(e.ill));
          chk("done_cycle", 32'(cyc), e.doneCyc);
        end
        if (prev_done) chk("done_single_pulse", 32'(prev_done), 32'd0);
      end else begin
        if (bus.WriteC || bus.ill || (bus.busC != '0) || (bus.busCsel != '0))
          chk("quiet_outside_wb", {bus.busC[29:0], bus.WriteC, bus.ill}, 32'd0);
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // driver: caller sits at a negedge; returns #1 after the accept edge
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] exp_c, input logic exp_w,
                       input logic [3:0] exp_f, input logic exp_ill, input logic hold);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = o;
    bus.busA  = a;
    bus.busB  = b;
    bus.dest  = d;
    @(posedge clk);
    #1;
    bus.start   = hold;
    bus.busA    = 32'hDEADBEEF;
    bus.busB    = 32'h00000013;
    bus.dest    = 5'd9;
    if (!hold) bus.op = OP_SUB;
    e.busC    = exp_c;
    e.sel     = d;
    e.writeC  = exp_w;
    e.flags   = exp_f;
    e.ill     = exp_ill;
    e.chkData = !exp_ill;
    e.doneCyc = 32'(cyc + ((o == OP_MUL) ? 32 : 1));
    exp_q.push_back(e);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // waits for done, then checks the following cycle is idle; ends at a negedge
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 32'(bus.done), 32'd1);
    end else begin
      if (bus.start) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk("busy_after_wb", 32'(bus.busy), 32'd0);
      chk("state_after_wb", 32'(dbgState), 32'(ST_IDLE));
    end
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] d, input logic [31:0] exp_c, input logic exp_w,
                     input logic [3:0] exp_f, input logic exp_ill);
    issue(o, a, b, d, exp_c, exp_w, exp_f, exp_ill, 1'b0);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.busA  = '0;
    bus.busB  = '0;
    bus.dest  = '0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_writec", 32'(bus.WriteC), 32'd0);
    chk("rst_busc", bus.busC, 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_state", 32'(dbgState), 32'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);

    // ADD signed overflow into the sign bit: Z=0 N=1 C=0 V=1
    run(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd3, 32'h80000000, 1'b1, 4'b0101, 1'b0);

    // reset in the 10th multiply cycle drops the op entirely
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.busA  = 32'h00000003;
    bus.busB  = 32'h00000005;
    bus.dest  = 5'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("mul_state", 32'(dbgState), 32'(ST_MUL));
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_writec", 32'(bus.WriteC), 32'd0);
    chk("midrst_busc", bus.busC, 32'd0);
    chk("midrst_buscsel", 32'(bus.busCsel), 32'd0);
    chk("midrst_flags", 32'(bus.flags), 32'd0);
    chk("midrst_ill", 32'(bus.ill), 32'd0);
    chk("midrst_state", 32'(dbgState), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (40) @(negedge clk);

    run(OP_SUB, 32'h00000001, 32'h00000002, 5'd5, 32'hFFFFFFFF, 1'b1, 4'b0110, 1'b0);
    run(OP_SLT, 32'h00000001, 32'h00000002, 5'd6, 32'h00000001, 1'b1, 4'b0000, 1'b0);

    // MUL with a stray start pulse in cycle n+5 that must be ignored
    issue(OP_MUL, 32'h00010003, 32'h00020005, 5'd7, 32'h000B000F, 1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.dest  = 5'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    run(OP_SRA, 32'h80000000, 32'h00000024, 5'd0, 32'hF8000000, 1'b0, 4'b0100, 1'b0);
    run(4'd13, 32'h12345678, 32'h00000001, 5'd4, 32'h00000000, 1'b0, 4'b0100, 1'b1);

    // start held high through the whole op, including the WB-ending edge
    issue(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 5'd8, 32'h0F0F0000, 1'b1, 4'b0000, 1'b0, 1'b1);
    wait_done();

    run(OP_OR,    32'h00000000, 32'h00000000, 5'd9,  32'h00000000, 1'b1, 4'b1000, 1'b0);
    run(OP_XOR,   32'hA5A5A5A5, 32'hFFFFFFFF, 5'd10, 32'h5A5A5A5A, 1'b1, 4'b0000, 1'b0);
    run(OP_SLL,   32'h00000001, 32'h0000001F, 5'd11, 32'h80000000, 1'b1, 4'b0100, 1'b0);
    run(OP_SRL,   32'h80000000, 32'h00000021, 5'd12, 32'h40000000, 1'b1, 4'b0000, 1'b0);
    run(OP_SLTU,  32'h00000001, 32'hFFFFFFFF, 5'd13, 32'h00000001, 1'b1, 4'b0000, 1'b0);
    run(OP_SLT,   32'h00000001, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1'b1, 4'b1000, 1'b0);
    run(OP_PASSB, 32'hCAFEF00D, 32'h12345678, 5'd15, 32'h12345678, 1'b1, 4'b0000, 1'b0);
    run(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 5'd16, 32'h00000000, 1'b1, 4'b1010, 1'b0);
    run(OP_SUB,   32'h80000000, 32'h00000001, 5'd17, 32'h7FFFFFFF, 1'b1, 4'b0001, 1'b0);
    run(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'h00000001, 1'b1, 4'b0000, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage sitting directly downstream of the CPU register bank. Latches the two operand buses read from the bank, performs one ALU operation (single-cycle logic/arithmetic/shift, or iterative 32-cycle multiply) and drives the write-back port (busC/busCsel/WriteC) back into the register bank. A start/busy/done handshake lets the CPU controller sequence it.

## Interface
- WIDTH, 32, data width; bit 0 is MSB/sign bit on all data buses
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  4  operation code (see Operation)
- busA  in  32  operand A from register bank
- busB  in  32  operand B from register bank
- dest  in  5  destination register index
- busC  out  32  write-back data
- busCsel  out  5  write-back register index
- WriteC  out  1  write-back strobe, one cycle
- busy  out  1  high while operation in flight
- done  out  1  one-cycle completion pulse
- flags  out  4  {Z,N,C,V}, held until next completion
- ill  out  1  one-cycle pulse, illegal op completed

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low 32 bits of unsigned product), 11 PASSB, 12-15 illegal.
- Shift amount = 5 LSBs of busB; SRA replicates bit 0.
- On accept (IDLE and start=1): capture busA, busB, op, dest into internal registers; later input changes have no effect.
- States: IDLE → EXEC (non-MUL) or MUL; EXEC → WB; MUL → WB after 32 iterations; WB → IDLE.
- MUL: shift-add, one multiplier bit per cycle, 32-bit accumulator mod 2^32.
- Flags at WB: Z = result==0; N = result bit 0; C = carry-out (ADD), borrow i.e. A<B unsigned (SUB), 0 otherwise; V = signed overflow (ADD/SUB), 0 otherwise.
- WriteC asserted in WB only if dest≠0 and op legal; busC/busCsel driven with result/dest during WB, 0 otherwise.
- Illegal op: no write, flags unchanged, done and ill pulse in WB.
- start while busy: ignored, no queuing.

## Timing
- Reset (async, any state): state=IDLE; busC=0, busCsel=0, WriteC=0, busy=0, done=0, flags=0, ill=0; in-flight op dropped, no write issued.
- Non-MUL: start high at edge n → EXEC cycle n+1 → WB cycle n+2 → IDLE n+3. busy high n+1..n+2; WriteC/done high exactly in n+2.
- MUL: MUL cycles n+1..n+32, WB n+33; busy high n+1..n+33.
- Earliest next accept: edge ending the WB cycle is not an accept edge; start sampled again from IDLE cycle onward (n+3 / n+34).
- done, WriteC, ill are never high for more than one consecutive cycle.
- Controller must hold register-bank enOut high during WB; block does not check it.

## Structure
- Shared package cpu_pkg: WIDTH, register-index width (5), opcode constants, state encoding, flag bit positions.
- Sub-module mul_iter: start/busy/done sequential shift-add multiplier, 32 iterations; alu_exec instantiates it and waits on its done.
- Remaining single-cycle datapath and FSM in alu_exec.

## Test plan
- Reset mid-MUL (cycle 10 of 32) → all outputs 0 next cycle, no WriteC ever, accepts new start after release.
- ADD 0x7FFFFFFF+1, dest=3 → WB at n+2: busC=0x80000000, busCsel=3, WriteC=1, flags Z=0 N=1 C=0 V=1.
- SUB 0x00000001−0x00000002, dest=5 → busC=0xFFFFFFFF, C=1, N=1, V=0; SLT same operands → busC=1.
- MUL 0x00010003×0x00020005, dest=7 → done at n+33, busC=0x000B000F; start pulsed at n+5 ignored.
- SRA 0x80000000 by busB=0x24 (amount 4) → 0xF8000000; dest=0 → done=1, WriteC=0.
- op=13 → done and ill pulse at n+2, WriteC=0, flags unchanged from previous op.
